// File: rtl/seg7_scan_driver_if.sv
// rtl/seg7_scan_driver_if.sv - display-side bundle of the stopwatch seven-segment scan driver
//
// Purpose: groups the BCD digit inputs, adjust/blink controls and the
// multiplexed display outputs of seg7_scan_driver into one port.
//
// Signals:
//   sec_one, sec_ten, min_one, min_ten  4-bit BCD digits (producer -> driver)
//   adj         adjust mode, enables blinking          (producer -> driver)
//   sel         0 = minutes pair blinks, 1 = seconds   (producer -> driver)
//   blink_tick  single-cycle blink-rate pulse          (producer -> driver)
//   seg         {g,f,e,d,c,b,a} cathodes, active-low   (driver -> display)
//   dp          decimal point, active-low              (driver -> display)
//   an          digit anodes, active-low one-hot       (driver -> display)
//
// Modports: master = digit producer / display observer, slave = scan driver.

interface seg7_scan_driver_if;
  logic [3:0] sec_one;
  logic [3:0] sec_ten;
  logic [3:0] min_one;
  logic [3:0] min_ten;
  logic       adj;
  logic       sel;
  logic       blink_tick;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;

  modport master (
    output sec_one, sec_ten, min_one, min_ten, adj, sel, blink_tick,
    input  seg, dp, an
  );

  modport slave (
    input  sec_one, sec_ten, min_one, min_ten, adj, sel, blink_tick,
    output seg, dp, an
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - time-multiplexed 4-digit common-anode seven-segment driver with adjust blink
//
// Purpose: scans the four stopwatch BCD digits onto a common-anode display,
// one digit per REFRESH_DIV clocks, and blanks the selected digit pair on
// alternate blink phases while in adjust mode. All outputs are registered.
//
// Ports:
//   clk   system clock
//   rst   synchronous, active-high reset
//   bus   seg7_scan_driver_if.slave: BCD digits, adj/sel/blink_tick in;
//         seg/dp/an out
//
// Parameters:
//   REFRESH_DIV  clocks each digit stays enabled (>= 2)
//   CNT_W        refresh counter width, 2**CNT_W >= REFRESH_DIV

module seg7_scan_driver #(
  parameter int REFRESH_DIV = 100000,
  parameter int CNT_W       = 17
) (
  input  logic                clk,
  input  logic                rst,
  seg7_scan_driver_if.slave   bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  logic [CNT_W-1:0] refresh_cnt;
  logic [1:0]       idx;
  logic             phase;

  logic [6:0]       seg_q;
  logic             dp_q;
  logic [3:0]       an_q;

  logic [3:0]       digit;
  logic [6:0]       seg_dec;
  logic             blank;
  logic [6:0]       seg_next;
  logic             dp_next;
  logic [3:0]       an_next;

  // Digit select for the currently scanned position.
  always_comb begin
    digit = bus.sec_one;
    case (idx)
      2'd0:    digit = bus.sec_one;
      2'd1:    digit = bus.sec_ten;
      2'd2:    digit = bus.min_one;
      default: digit = bus.min_ten;
    endcase
  end

  // BCD to active-low {g,f,e,d,c,b,a}; non-BCD codes show nothing.
  always_comb begin
    seg_dec = SEG_BLANK;
    case (digit)
      4'd0:    seg_dec = 7'b1000000;
      4'd1:    seg_dec = 7'b1111001;
      4'd2:    seg_dec = 7'b0100100;
      4'd3:    seg_dec = 7'b0110000;
      4'd4:    seg_dec = 7'b0011001;
      4'd5:    seg_dec = 7'b0010010;
      4'd6:    seg_dec = 7'b0000010;
      4'd7:    seg_dec = 7'b1111000;
      4'd8:    seg_dec = 7'b0000000;
      4'd9:    seg_dec = 7'b0010000;
      default: seg_dec = SEG_BLANK;
    endcase
  end

  // idx[1] separates the minutes pair (idx2/idx3) from the seconds pair
  // (idx0/idx1). adj is used live so dropping it unblanks on the next edge.
  always_comb begin
    blank    = bus.adj && phase && (bus.sel ? !idx[1] : idx[1]);
    seg_next = blank ? SEG_BLANK : seg_dec;
    dp_next  = !((idx == 2'd2) && !blank);
    an_next  = ~(4'b0001 << idx);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      refresh_cnt <= '0;
      idx         <= 2'd0;
      phase       <= 1'b0;
      seg_q       <= SEG_BLANK;
      dp_q        <= 1'b1;
      an_q        <= 4'b1111;
    end else begin
      if (refresh_cnt == CNT_LAST) begin
        refresh_cnt <= '0;
        idx         <= idx + 2'd1;
      end else begin
        refresh_cnt <= refresh_cnt + 1'b1;
      end

      if (!bus.adj) begin
        phase <= 1'b0;
      end else if (bus.blink_tick) begin
        phase <= !phase;
      end

      seg_q <= seg_next;
      dp_q  <= dp_next;
      an_q  <= an_next;
    end
  end

  assign bus.seg = seg_q;
  assign bus.dp  = dp_q;
  assign bus.an  = an_q;

endmodule
